// File: rtl/aq_axis_djpeg_seq.sv
// Frame sequencer: holds the JPEG decoder in reset between frames and gates its pixel stream onto AXI4-Stream video.
// Optional watchdog built when AQ_DJPEG_SEQ_WDT_EN is defined.
module aq_axis_djpeg_seq #(
    parameter int DATA_W     = 24,
    parameter int RST_CYCLES = 16,
    parameter int WDT_CYCLES = 1048576
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              START,
    input  logic              ABORT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [15:0]       FRAME_CNT,
    output logic              DEC_RST,
    input  logic              DEC_IDLE,
    input  logic              DEC_HDR_VALID,
    input  logic [15:0]       WIDTH,
    input  logic [15:0]       HEIGHT,
    output logic [15:0]       PIXELX,
    output logic [15:0]       PIXELY,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TUSER,
    output logic              M_AXIS_TLAST
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_q, err_d;
    logic        run, beat, x_last, y_last;
`ifdef AQ_DJPEG_SEQ_WDT_EN
    logic [31:0] wdt_q, wdt_d;
`endif

    assign run    = (state_q == S_RUN);
    assign beat   = run & S_AXIS_TVALID & M_AXIS_TREADY;
    assign x_last = (x_q == w_q - 16'd1);
    assign y_last = (y_q == h_q - 16'd1);

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
`ifdef AQ_DJPEG_SEQ_WDT_EN
        wdt_d       = '0;
`endif
        // ABORT overrides every other event, including START and a concurrent beat
        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        err_d     = 1'b0;
                        x_d       = '0;
                        y_d       = '0;
                        rst_cnt_d = 32'(RST_CYCLES - 1);
                        state_d   = S_RESET;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == '0) state_d = S_HDR;
                    else                 rst_cnt_d = rst_cnt_q - 32'd1;
                end
                S_HDR: begin
                    if (DEC_HDR_VALID) begin
                        w_d = WIDTH;
                        h_d = HEIGHT;
                        if (WIDTH == '0 || HEIGHT == '0) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        if (x_last) begin
                            x_d = '0;
                            y_d = y_q + 16'd1;
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                        if (x_last && y_last) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            state_d     = S_DONE;
                        end
                    end else if (DEC_IDLE) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
`ifdef AQ_DJPEG_SEQ_WDT_EN
            // Counts only while parked in HDR/RUN with no beat; any transition or beat restarts it
            if ((state_q == S_HDR || state_q == S_RUN) && state_d == state_q && !beat) begin
                if (wdt_q == 32'(WDT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdt_d = wdt_q + 32'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
`ifdef AQ_DJPEG_SEQ_WDT_EN
            wdt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
`ifdef AQ_DJPEG_SEQ_WDT_EN
            wdt_q       <= wdt_d;
`endif
        end
    end

    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_DONE);
    assign ERR           = err_q;
    assign FRAME_CNT     = frame_cnt_q;
    assign DEC_RST       = (state_q == S_IDLE) || (state_q == S_RESET);
    assign PIXELX        = x_q;
    assign PIXELY        = y_q;
    assign M_AXIS_TDATA  = S_AXIS_TDATA;
    assign M_AXIS_TVALID = S_AXIS_TVALID & run;
    assign S_AXIS_TREADY = M_AXIS_TREADY & run;
    assign M_AXIS_TUSER  = run & (x_q == '0) & (y_q == '0);
    assign M_AXIS_TLAST  = run & x_last;

endmodule

// File: tb/tb_aq_axis_djpeg_seq.sv
// Self-checking bench for aq_axis_djpeg_seq: vector table plus randomized frames against a beat-index model.
module tb_aq_axis_djpeg_seq;

    localparam int DW  = 24;
    localparam int RST = 4;
    localparam int WDT = 64;

    logic          clk = 1'b0;
    logic          aresetn, start, abort, busy, done, err, dec_rst;
    logic          dec_idle, hdr_valid;
    logic [15:0]   width, height, frame_cnt, px, py;
    logic [DW-1:0] s_tdata, m_tdata;
    logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tuser, m_tlast;

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;

    always #5 clk = ~clk;

    aq_axis_djpeg_seq #(.DATA_W(DW), .RST_CYCLES(RST), .WDT_CYCLES(WDT)) dut (
        .ACLK(clk), .ARESETN(aresetn), .START(start), .ABORT(abort),
        .BUSY(busy), .DONE(done), .ERR(err), .FRAME_CNT(frame_cnt),
        .DEC_RST(dec_rst), .DEC_IDLE(dec_idle), .DEC_HDR_VALID(hdr_valid),
        .WIDTH(width), .HEIGHT(height), .PIXELX(px), .PIXELY(py),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TUSER(m_tuser), .M_AXIS_TLAST(m_tlast)
    );

    typedef struct {
        logic        sv;
        logic        mr;
        logic        e_mv;
        logic        e_sr;
        logic        e_user;
        logic        e_last;
        logic [15:0] e_x;
        logic [15:0] e_y;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the sequencer in the cycle after the header has been accepted.
    task automatic start_frame(input int w, input int h);
        start = 1'b1;
        #1 chk("busy_before_start", 32'(busy), 0);
        cyc();
        start = 1'b0;
        #1 chk("busy_after_start", 32'(busy), 1);
        chk("err_cleared_by_start", 32'(err), 0);
        for (int i = 1; i <= RST; i++) begin
            chk("dec_rst_hold", 32'(dec_rst), 1);
            cyc();
            #1;
        end
        chk("dec_rst_release", 32'(dec_rst), 0);
        hdr_valid = 1'b1;
        width     = 16'(w);
        height    = 16'(h);
        cyc();
        hdr_valid = 1'b0;
        width     = 16'($urandom);
        height    = 16'($urandom);
    endtask

    // Reference: beat index k maps to x=k%w, y=k/w; the frame ends after beat w*h-1.
    task automatic run_frame(input int w, input int h, input int pv, input int pr);
        int k = 0;
        int n = w * h;
        int budget = 0;
        logic b;
        start_frame(w, h);
        while (k < n && budget < 4000) begin
            s_tvalid = ($urandom_range(99) < 32'(pv));
            m_tready = ($urandom_range(99) < 32'(pr));
            s_tdata  = DW'($urandom);
            #1;
            chk("rf_tuser", 32'(m_tuser), 32'(k == 0));
            chk("rf_tlast", 32'(m_tlast), 32'((k % w) == w - 1));
            chk("rf_px", 32'(px), 32'(k % w));
            chk("rf_py", 32'(py), 32'(k / w));
            chk("rf_mvalid", 32'(m_tvalid), 32'(s_tvalid));
            chk("rf_sready", 32'(s_tready), 32'(m_tready));
            chk("rf_tdata", 32'(m_tdata), 32'(s_tdata));
            chk("rf_done_early", 32'(done), 0);
            b = s_tvalid & m_tready;
            if (b) k++;
            budget++;
            cyc();
        end
        if (k < n) chk("rf_timeout_beats", 32'(k), 32'(n));
        s_tvalid = 1'b0;
        #1 chk("rf_done", 32'(done), 1);
        chk("rf_err", 32'(err), 0);
        exp_fc = (exp_fc + 1) % 65536;
        chk("rf_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        cyc();
        #1 chk("rf_idle_busy", 32'(busy), 0);
        chk("rf_done_clear", 32'(done), 0);
    endtask

    initial begin
        // W=4,H=2 with one source stall then sink toggling every cycle
        tbl[0]  = '{0, 1, 0, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 1, 1, 1, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 1, 0, 0, 0, 2, 0};
        tbl[5]  = '{1, 1, 1, 1, 0, 0, 2, 0};
        tbl[6]  = '{1, 0, 1, 0, 0, 1, 3, 0};
        tbl[7]  = '{1, 1, 1, 1, 0, 1, 3, 0};
        tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 1, 1, 1, 0, 0, 0, 1};
        tbl[10] = '{1, 0, 1, 0, 0, 0, 1, 1};
        tbl[11] = '{1, 1, 1, 1, 0, 0, 1, 1};
        tbl[12] = '{1, 0, 1, 0, 0, 0, 2, 1};
        tbl[13] = '{1, 1, 1, 1, 0, 0, 2, 1};
        tbl[14] = '{1, 0, 1, 0, 0, 1, 3, 1};
        tbl[15] = '{1, 1, 1, 1, 0, 1, 3, 1};

        aresetn = 1'b0; start = 1'b0; abort = 1'b0; dec_idle = 1'b0; hdr_valid = 1'b0;
        width = '0; height = '0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        repeat (3) cyc();
        aresetn  = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        s_tdata  = 24'h5a_c3_0f;
        #1;
        chk("rst_dec_rst", 32'(dec_rst), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_px", 32'(px), 0);
        chk("rst_py", 32'(py), 0);
        chk("rst_sready", 32'(s_tready), 0);
        chk("rst_mvalid", 32'(m_tvalid), 0);
        chk("rst_tuser", 32'(m_tuser), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tdata", 32'(m_tdata), 32'h5a_c3_0f);
        s_tvalid = 1'b0;
        cyc();

        // Nominal frame, then the backpressure table
        run_frame(4, 2, 100, 100);
        start_frame(4, 2);
        for (int i = 0; i < 16; i++) begin
            s_tvalid = tbl[i].sv;
            m_tready = tbl[i].mr;
            s_tdata  = DW'($urandom);
            #1;
            chk("tv_mvalid", 32'(m_tvalid), 32'(tbl[i].e_mv));
            chk("tv_sready", 32'(s_tready), 32'(tbl[i].e_sr));
            chk("tv_tuser", 32'(m_tuser), 32'(tbl[i].e_user));
            chk("tv_tlast", 32'(m_tlast), 32'(tbl[i].e_last));
            chk("tv_px", 32'(px), 32'(tbl[i].e_x));
            chk("tv_py", 32'(py), 32'(tbl[i].e_y));
            chk("tv_done", 32'(done), 0);
            cyc();
        end
        s_tvalid = 1'b0;
        #1 chk("tv_done_pulse", 32'(done), 1);
        chk("tv_err", 32'(err), 0);
        exp_fc++;
        chk("tv_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("tv_busy_done", 32'(busy), 1);
        cyc();
        #1 chk("tv_busy_idle", 32'(busy), 0);
        chk("tv_done_once", 32'(done), 0);

        // 1x1 image
        run_frame(1, 1, 100, 100);

        // Zero width
        start_frame(0, 5);
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        #1 chk("zs_done", 32'(done), 1);
        chk("zs_err", 32'(err), 1);
        chk("zs_sready", 32'(s_tready), 0);
        chk("zs_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        cyc();
        #1 chk("zs_busy", 32'(busy), 0);
        chk("zs_sready_idle", 32'(s_tready), 0);
        s_tvalid = 1'b0;
        cyc();

        // Truncated frame
        start_frame(4, 4);
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        repeat (10) cyc();
        s_tvalid = 1'b0;
        dec_idle = 1'b1;
        #1 chk("tr_px", 32'(px), 2);
        chk("tr_py", 32'(py), 2);
        cyc();
        dec_idle = 1'b0;
        #1 chk("tr_done", 32'(done), 1);
        chk("tr_err", 32'(err), 1);
        chk("tr_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        cyc();
        #1 chk("tr_busy", 32'(busy), 0);
        chk("tr_err_sticky", 32'(err), 1);

        // ABORT with START in idle: stays idle, ERR kept
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        #1 chk("as_busy", 32'(busy), 0);
        chk("as_err_kept", 32'(err), 1);

        // START mid-frame ignored, then ABORT together with beat 3
        start_frame(4, 2);
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        #1 chk("ig_px", 32'(px), 1);
        chk("ig_dec_rst", 32'(dec_rst), 0);
        cyc();
        cyc();
        #1 chk("ab_px_before", 32'(px), 3);
        abort = 1'b1;
        cyc();
        abort    = 1'b0;
        s_tvalid = 1'b0;
        #1 chk("ab_busy", 32'(busy), 0);
        chk("ab_dec_rst", 32'(dec_rst), 1);
        chk("ab_done", 32'(done), 0);
        chk("ab_err", 32'(err), 0);
        chk("ab_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        cyc();
        #1 chk("ab_done_later", 32'(done), 0);
        run_frame(4, 2, 100, 100);

        // Randomized frames
        for (int f = 0; f < 8; f++)
            run_frame(int'($urandom_range(5, 1)), int'($urandom_range(4, 1)), 60, 60);

`ifdef AQ_DJPEG_SEQ_WDT_EN
        begin
            int n = 0;
            start_frame(2, 2);
            s_tvalid = 1'b0;
            m_tready = 1'b1;
            while (n < 300) begin
                #1;
                if (done) break;
                n++;
                cyc();
            end
            chk("wdt_cycles", 32'(n), 32'(WDT));
            chk("wdt_err", 32'(err), 1);
            cyc();
        end
`else
        begin
            int seen = 0;
            start_frame(2, 2);
            s_tvalid = 1'b0;
            m_tready = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                #1;
                if (done) seen++;
                cyc();
            end
            chk("nowdt_done", 32'(seen), 0);
            chk("nowdt_busy", 32'(busy), 1);
            abort = 1'b1;
            cyc();
            abort = 1'b0;
        end
`endif

        // Synchronous reset mid-frame
        start_frame(3, 3);
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        cyc();
        cyc();
        aresetn = 1'b0;
        cyc();
        aresetn  = 1'b1;
        s_tvalid = 1'b0;
        #1 chk("mr_busy", 32'(busy), 0);
        chk("mr_px", 32'(px), 0);
        chk("mr_dec_rst", 32'(dec_rst), 1);
        chk("mr_frame_cnt", 32'(frame_cnt), 0);
        exp_fc = 0;
        cyc();
        run_frame(2, 3, 80, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aq_axis_djpeg_seq.md
# aq_axis_djpeg_seq

Frame sequencer for the JPEG decoder core. It holds the decoder in reset between frames and releases it for exactly one frame per START. It captures the decoded image size, then gates the decoder's pixel stream onto an AXI4-Stream video output, generating TUSER (start of frame) and TLAST (end of line). It sits between the AXI4-Lite control block (START/ABORT/status) and the decoder datapath, and reports DONE, ERR, the live pixel position and a frame count.

## Interface

**Parameters**
- DATA_W, 24, pixel data width.
- RST_CYCLES, 16, number of cycles DEC_RST is held after START (≥1).
- WDT_CYCLES, 1048576, watchdog limit in cycles without progress (used only with AQ_DJPEG_SEQ_WDT_EN).

**Ports**
- ACLK in 1: clock, all logic on rising edge.
- ARESETN in 1: synchronous, active-low reset.
- START in 1: one-cycle pulse that begins a frame; honoured only in S_IDLE.
- ABORT in 1: one-cycle pulse that returns to S_IDLE from any state.
- BUSY out 1: high in every state except S_IDLE.
- DONE out 1: one-cycle pulse at frame end (success or error).
- ERR out 1: sticky error flag; cleared by START.
- FRAME_CNT out 16: count of successfully completed frames; wraps 0xFFFF→0.
- DEC_RST out 1: decoder reset, active high.
- DEC_IDLE in 1: decoder idle/finished.
- DEC_HDR_VALID in 1: level; WIDTH/HEIGHT are valid.
- WIDTH in 16, HEIGHT in 16: decoded image size.
- PIXELX out 16, PIXELY out 16: position of the next pixel to be output.
- S_AXIS_TDATA in DATA_W, S_AXIS_TVALID in 1, S_AXIS_TREADY out 1: pixels from the decoder.
- M_AXIS_TDATA out DATA_W, M_AXIS_TVALID out 1, M_AXIS_TREADY in 1, M_AXIS_TUSER out 1, M_AXIS_TLAST out 1: video output.

## Operation

**States**
- S_IDLE: DEC_RST=1, streams blocked.
  - On START: clear ERR, x=y=0, load the reset counter with RST_CYCLES-1, go to S_RESET.
- S_RESET: DEC_RST=1; the counter decrements each cycle.
  - At 0: go to S_HDR (DEC_RST=0 from that cycle).
- S_HDR: wait for DEC_HDR_VALID=1, then latch WIDTH→w_r and HEIGHT→h_r.
  - If either value is 0: set ERR, go to S_DONE.
  - Otherwise go to S_RUN.
- S_RUN: stream pass-through.
  - beat = S_AXIS_TVALID & M_AXIS_TREADY.
  - On a beat:
    - if x==w_r-1, then x=0 and y=y+1;
    - otherwise x=x+1.
  - Last beat (x==w_r-1 and y==h_r-1): go to S_DONE and increment FRAME_CNT.
  - DEC_IDLE=1 without a beat, before the last beat: truncated frame; set ERR, go to S_DONE.
- S_DONE: DONE=1 for one cycle, then go to S_IDLE.

**Stream rules**
- M_AXIS_TDATA = S_AXIS_TDATA.
- M_AXIS_TVALID = S_AXIS_TVALID & (state==S_RUN).
- S_AXIS_TREADY = M_AXIS_TREADY & (state==S_RUN).
- M_AXIS_TUSER = (x==0 & y==0) in S_RUN.
- M_AXIS_TLAST = (x==w_r-1) in S_RUN.

**Arithmetic and counters**
- All comparisons are 16-bit unsigned against w_r-1 and h_r-1.
- w_r and h_r are not sampled again after S_HDR.
- PIXELX/PIXELY reflect x and y directly.

**Boundary conditions**
- ABORT together with START or a beat: ABORT wins. Next state is S_IDLE, no DONE, no FRAME_CNT change, ERR unchanged.
- START outside S_IDLE: ignored.
- 1×1 image: the first beat carries TUSER=1 and TLAST=1 and completes the frame.
- Source stalls (TVALID=0) or sink stalls (TREADY=0): counters hold.

## Timing

**Reset values**
- DEC_RST=1.
- BUSY=0, DONE=0, ERR=0.
- FRAME_CNT=0, PIXELX=PIXELY=0.
- S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TUSER=0, M_AXIS_TLAST=0.
- M_AXIS_TDATA follows its input.

**Latencies**
- START at cycle 0 → BUSY=1 at cycle 1. DEC_RST stays high for cycles 1..RST_CYCLES and is low from cycle RST_CYCLES+1.
- DEC_HDR_VALID sampled at cycle n → S_RUN at n+1.
- Stream path: zero latency, purely combinational, no buffering.
- Last beat at cycle n → DONE=1 at n+1, BUSY=0 at n+2, FRAME_CNT updated at n+1.
- ARESETN low mid-frame: all state returns to reset values on the next edge.

## Configuration

- AQ_DJPEG_SEQ_WDT_EN defined:
  - A watchdog counter runs in S_HDR and S_RUN.
  - It is cleared on state entry and on every beat.
  - On reaching WDT_CYCLES-1 it sets ERR and goes to S_DONE.
- Undefined:
  - No watchdog logic is built.
  - ERR comes only from a zero size or a truncated frame.
  - The sequencer can wait indefinitely.

## Test plan

- Nominal frame: START, DEC_HDR_VALID with W=4, H=2, 8 beats with TREADY=1.
  - TUSER on beat 0 only; TLAST on beats 3 and 7.
  - DONE one cycle after beat 7, FRAME_CNT=1, ERR=0.
- Backpressure: same frame with M_AXIS_TREADY toggling every cycle.
  - S_AXIS_TREADY mirrors it; PIXELX/PIXELY advance only on beats.
  - Identical TUSER/TLAST placement.
- Zero size: W=0, H=5 → ERR=1 and DONE pulse; FRAME_CNT unchanged; S_AXIS_TREADY never 1.
- Truncation: W=H=4, DEC_IDLE=1 after 10 beats → ERR=1, DONE, PIXELX=2, PIXELY=2.
- ABORT after beat 3, issued together with a beat → BUSY=0 next cycle, DEC_RST=1, no DONE, FRAME_CNT unchanged. A following START runs a full frame correctly.
- With AQ_DJPEG_SEQ_WDT_EN and WDT_CYCLES=64: stall S_AXIS_TVALID=0 in S_RUN → ERR and DONE after 64 cycles. Without the macro, no DONE after 1000 cycles.
